servo_pwm_varredura: RTL and testbench
======================================

# servo_pwm_varredura

Servo PWM generator for the turret sweep path. It sits directly downstream of the bouncing up/down position counter and converts the counter's position index into a fixed-period servo pulse. It also produces the `avanca` step pulse that drives that counter's `conta` input, so the sweep advances once every PERIODOS_POR_PASSO PWM periods. Position is sampled only at period boundaries, so a pulse is never truncated or stretched mid-period.

## Interface
- `PERIODO`, default 1000000: PWM period in clocks (20 ms at 50 MHz).
- `LARGURA_MIN`, default 50000: pulse width for position 0, in clocks (1 ms).
- `PASSO`, default 1000: extra pulse width per position step, in clocks.
- `POS_MAX`, default 49: highest legal position; larger inputs are clamped to this value.
- `PERIODOS_POR_PASSO`, default 5: PWM periods per `avanca` pulse.
- `N`, default 6: width of the position input.
- `NP`, default 20: width of the period and width counters; must hold PERIODO-1.
- `clock` input 1: single clock; all state changes on its rising edge.
- `zera_as` input 1: reset, asynchronous and active-high; clears all state.
- `habilita` input 1: run request; sampled only in PARADO and at period end.
- `posicao` input N: position index from the sweep counter's Q.
- `pwm` output 1: servo pulse.
- `fim_periodo` output 1: one-cycle pulse in the last cycle of each active period.
- `avanca` output 1: one-cycle pulse, connects to the counter's `conta`.
- `ativo` output 1: high while in state ATIVO.
- `largura` output NP: pulse width currently in use, in clocks.

## Operation
- Two-state FSM: PARADO and ATIVO. Internal registers:
  - `cnt`, NP bits.
  - `largura`, NP bits.
  - `nper`, period counter, width ceil(log2(PERIODOS_POR_PASSO)) bits.
- Width computation: `largura_calc = LARGURA_MIN + min(posicao, POS_MAX) * PASSO`.
  - Computed at NP bits with no overflow.
  - Parameter legality is LARGURA_MIN + POS_MAX*PASSO <= PERIODO-1, so the pulse always falls inside the period. The bench enforces this with an elaboration/sim assertion.
- PARADO:
  - Outputs: `cnt`=0, `pwm`=0, `ativo`=0.
  - On `habilita`=1: load `largura` <= `largura_calc`, `cnt` <= 0, `nper` <= 0, then go to ATIVO.
- ATIVO:
  - `pwm` = (`cnt` < `largura`), decoded from registers.
  - `cnt` increments by 1 each cycle.
  - When `cnt` == PERIODO-1, `fim_periodo`=1 for that cycle.
    - If `habilita`=1: `cnt` <= 0, `largura` <= `largura_calc`, stay in ATIVO.
    - If `habilita`=0: go to PARADO. `largura` holds its last value.
- `habilita` changes in the middle of a period have no effect. The current period always completes.
- `avanca` = `fim_periodo` AND (`nper` == PERIODOS_POR_PASSO-1).
  - At each `fim_periodo`, `nper` wraps to 0 when it equals PERIODOS_POR_PASSO-1, otherwise it increments.
  - An `avanca` still fires in the final period before PARADO if `nper` is due.
- `posicao` is sampled only on a load edge. The counter's response to `avanca` (new Q on the next edge) is picked up at the following period boundary.

## Timing
- Reset (async, at any time, including mid-pulse): on assertion, all of the following are 0 immediately with no clock edge: state PARADO, `cnt`, `largura`, `nper`, `pwm`, `fim_periodo`, `avanca`, `ativo`.
- Start latency: `habilita` is high at edge k. From cycle k+1, `ativo`=1 and `pwm`=1 with `cnt`=0.
- In ATIVO, `pwm` is high for exactly `largura` cycles and low for PERIODO-`largura` cycles.
- Period boundary: the `fim_periodo` cycle is followed by `cnt`=0 with the new `largura` already applied. There is no gap cycle between periods.
- Stop: the cycle after the final `fim_periodo` has `ativo`=0 and `pwm`=0.
- Back-to-back: if `habilita` returns high in the first PARADO cycle, ATIVO resumes on the next edge. That gives one idle cycle between periods.

## Test plan
Bench parameters: PERIODO=20, LARGURA_MIN=4, PASSO=2, POS_MAX=5, PERIODOS_POR_PASSO=3, N=4, NP=5.
- Reset/start: hold `zera_as` high, then release. All outputs stay 0 until `habilita`. With `posicao`=3 and `habilita`=1, the next cycle has `pwm`=1. `pwm` stays high 10 cycles and low 10, and `largura`=10.
- Clamp: `posicao`=0 gives a 4-cycle pulse. `posicao`=5 gives 14. `posicao`=9 gives 14, same as POS_MAX.
- Mid-period change: change `posicao` from 1 to 4 at `cnt`=2. The current pulse stays 6 cycles. The next period's pulse is 12 cycles.
- Step pulse: run 9 periods. `avanca` pulses exactly 3 times, coinciding with `fim_periodo` of periods 3, 6 and 9. Feeding `avanca` into the sweep counter makes `largura` step at each third boundary.
- Stop: drop `habilita` at `cnt`=5. The period runs to `cnt`=19 with `fim_periodo`=1, then `ativo`=0 and `pwm`=0.
- Async reset: assert `zera_as` while `pwm`=1 at `cnt`=3. `pwm` and all other outputs go to 0 immediately. After release, the block stays in PARADO until `habilita`.

Source files
------------

// File: rtl/servo_pwm_varredura.sv
// servo_pwm_varredura: servo PWM generator for the turret sweep path.
// Converts the sweep counter's position index into a fixed-period servo pulse.
// It also emits a step pulse that advances that counter once every
// PERIODOS_POR_PASSO PWM periods. Position is sampled only at period
// boundaries, so a pulse is never truncated or stretched mid-period.
//
// Ports:
//   clock        - single clock, rising edge
//   zera_as      - asynchronous active-high reset, clears all state
//   habilita     - run request, sampled in PARADO and at period end
//   posicao      - position index from the sweep counter's Q
//   pwm          - servo pulse
//   fim_periodo  - one-cycle pulse in the last cycle of each active period
//   avanca       - one-cycle step pulse to the sweep counter's conta input
//   ativo        - high while running
//   largura      - pulse width currently in use, in clocks
module servo_pwm_varredura #(
  parameter int unsigned PERIODO            = 1000000,
  parameter int unsigned LARGURA_MIN        = 50000,
  parameter int unsigned PASSO              = 1000,
  parameter int unsigned POS_MAX            = 49,
  parameter int unsigned PERIODOS_POR_PASSO = 5,
  parameter int unsigned N                  = 6,
  parameter int unsigned NP                 = 20
) (
  input  logic          clock,
  input  logic          zera_as,
  input  logic          habilita,
  input  logic [N-1:0]  posicao,
  output logic          pwm,
  output logic          fim_periodo,
  output logic          avanca,
  output logic          ativo,
  output logic [NP-1:0] largura
);

  // A single period per step still needs a one-bit counter to exist.
  localparam int unsigned NPW = (PERIODOS_POR_PASSO > 1) ? $clog2(PERIODOS_POR_PASSO) : 1;

  localparam logic [NP-1:0]  CNT_ULT  = NP'(PERIODO - 1);
  localparam logic [NPW-1:0] NPER_ULT = NPW'(PERIODOS_POR_PASSO - 1);
  localparam logic [NP-1:0]  L_MIN    = NP'(LARGURA_MIN);
  localparam logic [NP-1:0]  L_PASSO  = NP'(PASSO);
  localparam logic [NP-1:0]  POS_LIM  = NP'(POS_MAX);

  typedef enum logic {
    PARADO = 1'b0,
    ATIVO  = 1'b1
  } estado_t;

  estado_t        estado;
  estado_t        estado_prox;
  logic [NP-1:0]  cnt;
  logic [NPW-1:0] nper;
  logic [NP-1:0]  pos_lim;
  logic [NP-1:0]  largura_calc;
  logic           carga;

  // Clamp the position to the legal range before scaling it to a width.
  always_comb begin
    pos_lim = NP'(posicao);
    if (32'(posicao) > POS_MAX) begin
      pos_lim = POS_LIM;
    end
  end

  // Legal parameters guarantee this sum stays below PERIODO at NP bits.
  assign largura_calc = L_MIN + pos_lim * L_PASSO;

  // State register.
  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      estado <= PARADO;
    end else begin
      estado <= estado_prox;
    end
  end

  // Next-state logic: leave ATIVO only at the end of a complete period.
  always_comb begin
    estado_prox = estado;
    case (estado)
      PARADO: begin
        if (habilita) begin
          estado_prox = ATIVO;
        end
      end
      ATIVO: begin
        if ((cnt == CNT_ULT) && !habilita) begin
          estado_prox = PARADO;
        end
      end
      default: estado_prox = PARADO;
    endcase
  end

  // Output decode, driven from registers only, so reset clears it at once.
  always_comb begin
    pwm         = 1'b0;
    fim_periodo = 1'b0;
    avanca      = 1'b0;
    ativo       = 1'b0;
    carga       = 1'b0;
    case (estado)
      PARADO: begin
        carga = habilita;
      end
      ATIVO: begin
        ativo = 1'b1;
        pwm   = (cnt < largura);
        if (cnt == CNT_ULT) begin
          fim_periodo = 1'b1;
          avanca      = (nper == NPER_ULT);
          carga       = habilita;
        end
      end
      default: begin
        carga = 1'b0;
      end
    endcase
  end

  // Datapath: period counter, latched width and the periods-per-step counter.
  always_ff @(posedge clock or posedge zera_as) begin
    if (zera_as) begin
      cnt     <= '0;
      largura <= '0;
      nper    <= '0;
    end else begin
      // The width only changes on a load, so it holds through PARADO.
      if (carga) begin
        largura <= largura_calc;
      end
      if (estado == PARADO) begin
        cnt <= '0;
        if (carga) begin
          nper <= '0;
        end
      end else if (fim_periodo) begin
        cnt <= '0;
        if (nper == NPER_ULT) begin
          nper <= '0;
        end else begin
          nper <= nper + NPW'(1);
        end
      end else begin
        cnt <= cnt + NP'(1);
      end
    end
  end

endmodule

// File: tb/tb_servo_pwm_varredura.sv
// tb_servo_pwm_varredura: directed bench for servo_pwm_varredura with
// small parameters (20-cycle period, widths 4..14, step every 3 periods).
module tb_servo_pwm_varredura;

  localparam int PERIODO     = 20;
  localparam int LARGURA_MIN = 4;
  localparam int PASSO       = 2;
  localparam int POS_MAX     = 5;
  localparam int PPP         = 3;
  localparam int N           = 4;
  localparam int NP          = 5;

  logic          clock = 1'b0;
  logic          zera_as;
  logic          habilita;
  logic [N-1:0]  posicao;
  logic          pwm;
  logic          fim_periodo;
  logic          avanca;
  logic          ativo;
  logic [NP-1:0] largura;

  // Stand-in for the upstream sweep counter, stepped by avanca.
  logic [N-1:0]  pos_drv;
  logic [N-1:0]  sweep_q;
  logic          sweep_en;
  logic          sweep_clr;

  int n_pass  = 0;
  int n_total = 0;
  int p_mod   = 0;
  int av_sum  = 0;

  typedef struct {
    logic [N-1:0] pos;
    int           exp_larg;
  } vec_t;

  vec_t tbl [6];
  int   sweep_exp [9];

  always #5 clock = ~clock;

  assign posicao = sweep_en ? sweep_q : pos_drv;

  always @(posedge clock) begin
    if (sweep_clr) sweep_q <= '0;
    else if (sweep_en && avanca) sweep_q <= sweep_q + 4'd1;
  end

  servo_pwm_varredura #(
    .PERIODO(PERIODO), .LARGURA_MIN(LARGURA_MIN), .PASSO(PASSO),
    .POS_MAX(POS_MAX), .PERIODOS_POR_PASSO(PPP), .N(N), .NP(NP)
  ) dut (
    .clock(clock), .zera_as(zera_as), .habilita(habilita), .posicao(posicao),
    .pwm(pwm), .fim_periodo(fim_periodo), .avanca(avanca), .ativo(ativo),
    .largura(largura)
  );

  initial begin
    assert (LARGURA_MIN + POS_MAX * PASSO <= PERIODO - 1)
      else $fatal(1, "FAIL param_legality: widest pulse exceeds period");
  end

  task automatic check(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int outs();
    return int'({pwm, fim_periodo, avanca, ativo, largura});
  endfunction

  // Measures one full period starting at cnt=0; optional mid-period input change.
  task automatic period_chk(input string nm, input int exp_hi, input int act_at,
                            input logic [N-1:0] act_pos, input logic act_hab);
    int hi, fim_n, fim_at, av_tot, av_last, exp_av;
    hi = 0; fim_n = 0; fim_at = -1; av_tot = 0; av_last = 0;
    exp_av = (p_mod == PPP - 1) ? 1 : 0;
    p_mod  = (p_mod + 1) % PPP;
    for (int c = 0; c < PERIODO; c++) begin
      if (c == act_at) begin
        pos_drv  = act_pos;
        habilita = act_hab;
      end
      if (pwm) hi++;
      if (fim_periodo) begin fim_n++; fim_at = c; end
      if (avanca) av_tot++;
      if (avanca && c == PERIODO - 1) av_last++;
      tick();
    end
    av_sum += av_tot;
    check({nm, "_pwm_high"}, hi, exp_hi);
    check({nm, "_fim_n100_at"}, fim_n * 100 + fim_at, 100 + PERIODO - 1);
    check({nm, "_avanca_tot2_last"}, av_tot * 2 + av_last, exp_av * 3);
  endtask

  initial begin
    tbl[0] = '{pos: 4'd0,  exp_larg: 4};
    tbl[1] = '{pos: 4'd5,  exp_larg: 14};
    tbl[2] = '{pos: 4'd9,  exp_larg: 14};
    tbl[3] = '{pos: 4'd3,  exp_larg: 10};
    tbl[4] = '{pos: 4'd15, exp_larg: 14};
    tbl[5] = '{pos: 4'd2,  exp_larg: 8};
    sweep_exp = '{4, 4, 4, 4, 6, 6, 6, 8, 8};

    zera_as = 1'b1; habilita = 1'b0; pos_drv = '0;
    sweep_en = 1'b0; sweep_clr = 1'b0;
    repeat (3) tick();
    check("reset_outs", outs(), 0);
    zera_as = 1'b0;
    repeat (4) tick();
    check("idle_outs", outs(), 0);

    // Start with posicao=3: width 10 from the very next cycle.
    pos_drv = 4'd3; habilita = 1'b1;
    tick();
    p_mod = 0;
    check("start_pwm_ativo_fim", int'({pwm, ativo, fim_periodo}), 6);
    check("start_largura", int'(largura), 10);
    period_chk("start", 10, -1, '0, 1'b1);

    // Width table incl. clamp; new posicao set at cnt=0 only takes effect next period.
    begin
      int prev;
      prev = 10;
      for (int i = 0; i < 6; i++) begin
        period_chk($sformatf("tbl%0d", i), prev, 0, tbl[i].pos, 1'b1);
        check($sformatf("tbl%0d_largura", i), int'(largura), tbl[i].exp_larg);
        prev = tbl[i].exp_larg;
      end
      period_chk("tbl_last", prev, 0, 4'd1, 1'b1);
    end

    // Mid-period change 1 -> 4 at cnt=2.
    check("mid_largura_a", int'(largura), 6);
    period_chk("mid_a", 6, 2, 4'd4, 1'b1);
    check("mid_largura_b", int'(largura), 12);
    period_chk("mid_b", 12, -1, '0, 1'b1);

    // Stop: habilita dropped at cnt=5, period still completes.
    period_chk("stop", 12, 5, 4'd4, 1'b0);
    check("stop_ativo_pwm_fim", int'({ativo, pwm, fim_periodo}), 0);
    check("stop_largura_hold", int'(largura), 12);
    repeat (2) tick();
    check("stop_idle_ativo", int'({ativo, pwm}), 0);

    // Sweep: avanca feeds the counter model, width steps follow.
    sweep_clr = 1'b1;
    tick();
    sweep_clr = 1'b0; sweep_en = 1'b1; habilita = 1'b1;
    tick();
    p_mod = 0; av_sum = 0;
    check("sweep_start_pwm", int'({pwm, ativo}), 3);
    for (int p = 0; p < 9; p++) begin
      period_chk($sformatf("sweep_p%0d", p + 1), sweep_exp[p], -1, '0, 1'b1);
    end
    check("sweep_avanca_total", av_sum, 3);
    check("sweep_counter_q", int'(sweep_q), 3);

    // Async reset mid-pulse at cnt=3, no clock edge needed.
    repeat (3) tick();
    check("pre_reset_pwm", int'(pwm), 1);
    #2 zera_as = 1'b1;
    #1 check("async_reset_outs", outs(), 0);
    sweep_en = 1'b0; habilita = 1'b0; pos_drv = 4'd3;
    tick();
    zera_as = 1'b0;
    repeat (3) tick();
    check("post_reset_idle", outs(), 0);
    habilita = 1'b1;
    tick();
    check("restart_pwm_ativo", int'({pwm, ativo}), 3);
    check("restart_largura", int'(largura), 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
